led_scan_driver: RTL and testbench



---
 rtl/led_scan_driver.sv | 148 ++++++++++++++
 tb/tb_led_scan_driver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_driver.sv
// led_scan_driver: scans a snapshotted 8x8 red/green frame onto the LED
// matrix one line at a time. Each line gets BLANK dark cycles to suppress
// ghosting, then DWELL lit cycles. The frame is captured once per frame,
// at the start of line 0, so a scan never mixes two frames.
module led_scan_driver #(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0][7:0] red_array,
    input  logic [7:0][7:0] green_array,
    output logic [7:0]      line_sel,
    output logic [7:0]      red_drive,
    output logic [7:0]      green_drive,
    output logic            frame_start
);

    localparam int MAX_PHASE = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0][7:0] snap_red_q, snap_red_d;
    logic [7:0][7:0] snap_green_q, snap_green_d;
    logic [7:0]      line_sel_q, line_sel_d;
    logic [7:0]      red_drive_q, red_drive_d;
    logic [7:0]      green_drive_q, green_drive_d;
    logic            frame_start_q, frame_start_d;

    // Next-state logic: phase counting, line advance and frame snapshot.
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        cnt_d         = cnt_q;
        snap_red_d    = snap_red_q;
        snap_green_d  = snap_green_q;
        frame_start_d = 1'b0;

        if (!enable) begin
            // Dropping enable always wins, including over a frame wrap.
            state_d = ST_IDLE;
            s_d     = 3'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d       = ST_BLANK;
                    s_d           = 3'd0;
                    cnt_d         = '0;
                    snap_red_d    = red_array;
                    snap_green_d  = green_array;
                    frame_start_d = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        s_d     = s_q + 3'd1;
                        if (s_q == 3'd7) begin
                            // Last line done: fresh frame starts here.
                            snap_red_d    = red_array;
                            snap_green_d  = green_array;
                            frame_start_d = 1'b1;
                        end else begin
                            frame_start_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    s_d     = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered drives line up
    // with the state they belong to.
    always_comb begin
        line_sel_d    = 8'd0;
        red_drive_d   = 8'd0;
        green_drive_d = 8'd0;
        if (state_d == ST_SHOW) begin
            line_sel_d    = 8'd1 << s_d;
            red_drive_d   = snap_red_d[s_d];
            green_drive_d = snap_green_d[s_d];
        end else begin
            line_sel_d    = 8'd0;
            red_drive_d   = 8'd0;
            green_drive_d = 8'd0;
        end
    end

    // State, snapshot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            s_q           <= 3'd0;
            cnt_q         <= '0;
            snap_red_q    <= '0;
            snap_green_q  <= '0;
            line_sel_q    <= 8'd0;
            red_drive_q   <= 8'd0;
            green_drive_q <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            cnt_q         <= cnt_d;
            snap_red_q    <= snap_red_d;
            snap_green_q  <= snap_green_d;
            line_sel_q    <= line_sel_d;
            red_drive_q   <= red_drive_d;
            green_drive_q <= green_drive_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign line_sel    = line_sel_q;
    assign red_drive   = red_drive_q;
    assign green_drive = green_drive_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Testbench for led_scan_driver (DWELL=4, BLANK=2, frame period 48).
// A time-based frame model pushes expected outputs to a scoreboard queue as
// each input set is driven; the sample after the next clock edge pops and
// compares. A table of hand-derived checkpoints covers the basic scan.
module tb_led_scan_driver;

    localparam int B = 2;
    localparam int D = 4;
    localparam int L = B + D;
    localparam int P = 8 * L;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [7:0][7:0] red_array;
    logic [7:0][7:0] green_array;
    logic [7:0]      line_sel;
    logic [7:0]      red_drive;
    logic [7:0]      green_drive;
    logic            frame_start;

    led_scan_driver #(.DWELL(D), .BLANK(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .red_array   (red_array),
        .green_array (green_array),
        .line_sel    (line_sel),
        .red_drive   (red_drive),
        .green_drive (green_drive),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ls;
        logic [7:0] rd;
        logic [7:0] gd;
        logic       fs;
    } obs_t;

    typedef struct {
        int   n;
        obs_t req;
    } vec_t;

    obs_t            sb_q[$];
    obs_t            trace[0:255];
    int              tidx;
    int              errors = 0;
    int              checks = 0;

    bit              m_run;
    int              m_t;
    logic [7:0][7:0] m_red;
    logic [7:0][7:0] m_green;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t req);
        chk({name, ".line_sel"},    act.ls, req.ls);
        chk({name, ".red_drive"},   act.rd, req.rd);
        chk({name, ".green_drive"}, act.gd, req.gd);
        chk({name, ".frame_start"}, {7'd0, act.fs}, {7'd0, req.fs});
    endtask

    // Drive one cycle of inputs, predict the result, then check it.
    task automatic step(input logic rst, input logic en);
        obs_t e;
        obs_t got;
        int   line;
        int   ph;
        reset  = rst;
        enable = en;
        e      = '0;
        if (rst) begin
            m_run   = 1'b0;
            m_red   = '0;
            m_green = '0;
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            if (!m_run) begin
                m_run   = 1'b1;
                m_t     = 0;
                m_red   = red_array;
                m_green = green_array;
                e.fs    = 1'b1;
            end else begin
                m_t++;
                if (m_t == P) begin
                    m_t     = 0;
                    m_red   = red_array;
                    m_green = green_array;
                    e.fs    = 1'b1;
                end
            end
            line = m_t / L;
            ph   = m_t % L;
            if (ph >= B) begin
                e.ls = 8'd1 << line;
                e.rd = m_red[line];
                e.gd = m_green[line];
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = {line_sel, red_drive, green_drive, frame_start};
        chk_obs($sformatf("sb[%0d]", tidx), got, sb_q.pop_front());
        checks++;
        if (((line_sel & (line_sel - 8'd1)) != 8'd0) ||
            ((line_sel == 8'd0) && ((red_drive | green_drive) != 8'd0))) begin
            errors++;
            $display("FAIL invariant[%0d]: line_sel=%h red=%h green=%h", tidx,
                     line_sel, red_drive, green_drive);
        end
        if (tidx >= 0 && tidx < 256) trace[tidx] = got;
        tidx++;
    endtask

    vec_t vecs[$];
    int   fs_cnt;
    int   guard;

    initial begin
        // Hand-derived checkpoints for the basic scan; n = edges after E0.
        vecs.push_back('{0,  '{8'h00, 8'h00, 8'h00, 1'b1}});
        vecs.push_back('{1,  '{8'h00, 8'h00, 8'h00, 1'b0}});
        vecs.push_back('{2,  '{8'h01, 8'h01, 8'h00, 1'b0}});
        vecs.push_back('{5,  '{8'h01, 8'h01, 8'h00, 1'b0}});
        vecs.push_back('{6,  '{8'h00, 8'h00, 8'h00, 1'b0}});
        vecs.push_back('{8,  '{8'h02, 8'h02, 8'h00, 1'b0}});
        vecs.push_back('{14, '{8'h04, 8'h04, 8'h00, 1'b0}});
        vecs.push_back('{20, '{8'h08, 8'h08, 8'hFF, 1'b0}});
        vecs.push_back('{23, '{8'h08, 8'h08, 8'hFF, 1'b0}});
        vecs.push_back('{26, '{8'h10, 8'h10, 8'h00, 1'b0}});
        vecs.push_back('{32, '{8'h20, 8'h20, 8'h00, 1'b0}});
        vecs.push_back('{38, '{8'h40, 8'h40, 8'h00, 1'b0}});
        vecs.push_back('{44, '{8'h80, 8'h80, 8'h00, 1'b0}});
        vecs.push_back('{47, '{8'h80, 8'h80, 8'h00, 1'b0}});
        vecs.push_back('{48, '{8'h00, 8'h00, 8'h00, 1'b1}});
        vecs.push_back('{49, '{8'h00, 8'h00, 8'h00, 1'b0}});
        vecs.push_back('{68, '{8'h08, 8'h08, 8'h00, 1'b0}});
        vecs.push_back('{71, '{8'h08, 8'h08, 8'h00, 1'b0}});

        reset       = 1'b1;
        enable      = 1'b1;
        red_array   = '0;
        green_array = '0;
        m_run       = 1'b0;
        m_t         = 0;
        m_red       = '0;
        m_green     = '0;
        tidx        = 0;

        // Reset hold with enable high.
        repeat (3) step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) chk_obs($sformatf("reset_hold[%0d]", i), trace[i], '0);

        // Basic scan plus tearing guard on green line 3.
        for (int s = 0; s < 8; s++) red_array[s] = 8'h01 << s;
        green_array    = '0;
        green_array[3] = 8'hFF;
        tidx = 0;
        for (int n = 0; n < 78; n++) begin
            if (n == 10) green_array[3] = 8'h00;
            step(1'b0, 1'b1);
        end
        foreach (vecs[i]) chk_obs($sformatf("scan_n%0d", vecs[i].n), trace[vecs[i].n], vecs[i].req);

        // Enable drop in the middle of line 5 SHOW (n = 80..83).
        repeat (4) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("drop.before", trace[81].ls, 8'h20);
        chk_obs("drop.after", trace[82], '0);
        step(1'b0, 1'b0);

        // Re-enable restarts at line 0 with one frame_start.
        tidx = 0;
        repeat (10) step(1'b0, 1'b1);
        chk_obs("reen_n0", trace[0], '{8'h00, 8'h00, 8'h00, 1'b1});
        chk_obs("reen_n1", trace[1], '0);
        chk_obs("reen_n2", trace[2], '{8'h01, 8'h01, 8'h00, 1'b0});
        fs_cnt = 0;
        for (int i = 0; i < 10; i++) fs_cnt += int'(trace[i].fs);
        chk("reen.fs_count", 8'(fs_cnt), 8'd1);

        // Reset during line 2 SHOW (n = 14..17).
        repeat (6) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst.before", trace[15].ls, 8'h04);
        chk_obs("rst.after", trace[16], '0);
        step(1'b1, 1'b1);
        tidx = 0;
        repeat (4) step(1'b0, 1'b1);
        chk_obs("rst_rel_n0", trace[0], '{8'h00, 8'h00, 8'h00, 1'b1});
        chk_obs("rst_rel_n2", trace[2], '{8'h01, 8'h01, 8'h00, 1'b0});

        // Three frames with arrays churning every cycle.
        for (int n = 0; n < 3 * P; n++) begin
            for (int i = 0; i < 8; i++) begin
                red_array[i]   = 8'($urandom);
                green_array[i] = 8'($urandom);
            end
            step(1'b0, 1'b1);
        end

        // Enable drop on the very edge that would wrap the frame.
        guard = 0;
        while (m_t != P - 1 && guard < 2 * P) begin
            step(1'b0, 1'b1);
            guard++;
        end
        step(1'b0, 1'b0);
        chk("wrap_drop.fs", {7'd0, frame_start}, 8'd0);
        chk("wrap_drop.ls", line_sel, 8'd0);
        step(1'b0, 1'b1);
        chk("wrap_reen.fs", {7'd0, frame_start}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
